// File: rtl/px_ss_ctrl_if.sv
// px_ss_if: subsampling parameter bundle driven by px_ss_ctrl.
//   master : controller side (drives all fields)
//   slave  : subsampler side (reads all fields)
// All fields are RES_WIDTH bits; zero in every field means pass-through.
interface px_ss_if #(
    parameter int RES_WIDTH = 16
);
    logic [RES_WIDTH-1:0] px_skip_interval;
    logic [RES_WIDTH-1:0] px_to_skip;
    logic [RES_WIDTH-1:0] add_px_skip_interval;
    logic [RES_WIDTH-1:0] ln_skip_interval;
    logic [RES_WIDTH-1:0] ln_to_skip;
    logic [RES_WIDTH-1:0] add_ln_skip_interval;

    modport master (
        output px_skip_interval, px_to_skip, add_px_skip_interval,
        output ln_skip_interval, ln_to_skip, add_ln_skip_interval
    );

    modport slave (
        input px_skip_interval, px_to_skip, add_px_skip_interval,
        input ln_skip_interval, ln_to_skip, add_ln_skip_interval
    );
endinterface

// File: rtl/px_ss_ctrl.sv
// px_ss_ctrl: converts a source/target resolution pair into pixel and line
// subsampling parameters using one shared restoring divider (one quotient
// bit per cycle, RES_WIDTH+1 cycles per division, four divisions per request).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cfg_valid_i/ready_o   request handshake; resolutions captured on accept
//   src/dst_res_x/y_i     source and target resolution per axis
//   frame_start_i         frame-start pulse from the subsampler input
//   px_ss_o               committed subsampling parameters (px_ss_if.master)
//   busy_o                division sequence running
//   pending_o             computed set waiting for frame start
//   update_o              one-cycle pulse after px_ss_o changes
//   cfg_err_o             last accepted request was invalid
//
// Build option: define PX_SS_CTRL_FRAME_SYNC_EN to hold results in PEND until
// frame_start_i; otherwise results commit one cycle after computation ends.
module px_ss_ctrl #(
    parameter int RES_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [RES_WIDTH-1:0] src_res_x_i,
    input  logic [RES_WIDTH-1:0] dst_res_x_i,
    input  logic [RES_WIDTH-1:0] src_res_y_i,
    input  logic [RES_WIDTH-1:0] dst_res_y_i,
    input  logic                 frame_start_i,
    px_ss_if.master              px_ss_o,
    output logic                 busy_o,
    output logic                 pending_o,
    output logic                 update_o,
    output logic                 cfg_err_o
);

    localparam int W  = RES_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef logic [W:0] wide_t;

    typedef enum logic [2:0] {
        IDLE, CALC_X0, CALC_X1, CALC_Y0, CALC_Y1, PEND
    } state_t;

    // Per-axis classification. For both reduction modes the first divisor
    // equals the second dividend (drop for 2D>=S, D otherwise).
    typedef struct packed {
        logic  eq;
        logic  inv;
        logic  big;
        wide_t div1;
        wide_t div2;
    } axis_t;

    function automatic axis_t classify(input logic [W-1:0] s, input logic [W-1:0] d);
        axis_t a;
        wide_t sw;
        wide_t dw;
        sw     = {1'b0, s};
        dw     = {1'b0, d};
        a.eq   = (dw == sw);
        a.inv  = !a.eq && ((dw == '0) || (dw > sw));
        a.big  = ({d, 1'b0} >= sw);
        a.div2 = a.big ? (sw - dw) : dw;
        // Degenerate axes still run both divisions; divide by 1 to stay defined.
        a.div1 = (a.eq || a.inv) ? wide_t'(1) : a.div2;
        return a;
    endfunction

    state_t state, next_state;

    axis_t          x_cls, y_cls;
    logic [W-1:0]   y_src;
    logic           err;
    logic           rz;

    wide_t          div_rem, div_quo, div_dvs;
    logic [CW-1:0]  div_cnt;
    wide_t          rem_sh, rem_nx, quo_nx;
    logic           ge, last;

    logic [W-1:0]   st_pi, st_pt, st_pa, st_li, st_lt, st_la;

    logic           accept;
    logic           commit;
    logic           commit_q;
    axis_t          in_x_cls, in_y_cls;

    assign accept   = cfg_valid_i && cfg_ready_o;
    assign in_x_cls = classify(src_res_x_i, dst_res_x_i);
    assign in_y_cls = classify(src_res_y_i, dst_res_y_i);

    // Restoring divider step.
    always_comb begin
        rem_sh = {div_rem[W-1:0], div_quo[W]};
        ge     = (rem_sh >= div_dvs);
        rem_nx = ge ? (rem_sh - div_dvs) : rem_sh;
        quo_nx = {div_quo[W-1:0], ge};
        last   = (div_cnt == CW'(W));
    end

`ifdef PX_SS_CTRL_FRAME_SYNC_EN
    assign commit = (state == PEND) && frame_start_i;
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start_i;
    assign commit = commit_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        cfg_ready_o = 1'b0;
        busy_o      = 1'b0;
        pending_o   = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready_o = !rst_i;
                if (accept) next_state = CALC_X0;
            end
            CALC_X0: begin
                busy_o = 1'b1;
                if (last) next_state = CALC_X1;
            end
            CALC_X1: begin
                busy_o = 1'b1;
                if (last) next_state = CALC_Y0;
            end
            CALC_Y0: begin
                busy_o = 1'b1;
                if (last) next_state = CALC_Y1;
            end
            CALC_Y1: begin
                busy_o = 1'b1;
                if (last) begin
`ifdef PX_SS_CTRL_FRAME_SYNC_EN
                    next_state = err ? IDLE : PEND;
`else
                    next_state = IDLE;
`endif
                end
            end
            PEND: begin
                cfg_ready_o = !rst_i;
`ifdef PX_SS_CTRL_FRAME_SYNC_EN
                pending_o   = 1'b1;
`endif
                // A coincident frame start commits the old set; the new request still wins the state.
                if (accept)             next_state = CALC_X0;
                else if (frame_start_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            px_ss_o.px_skip_interval     <= '0;
            px_ss_o.px_to_skip           <= '0;
            px_ss_o.add_px_skip_interval <= '0;
            px_ss_o.ln_skip_interval     <= '0;
            px_ss_o.ln_to_skip           <= '0;
            px_ss_o.add_ln_skip_interval <= '0;
            update_o <= 1'b0;
            cfg_err_o <= 1'b0;
            commit_q <= 1'b0;
            div_cnt  <= '0;
        end else begin
            update_o <= 1'b0;
            commit_q <= (state == CALC_Y1) && last && !err;

            if (commit) begin
                px_ss_o.px_skip_interval     <= st_pi;
                px_ss_o.px_to_skip           <= st_pt;
                px_ss_o.add_px_skip_interval <= st_pa;
                px_ss_o.ln_skip_interval     <= st_li;
                px_ss_o.ln_to_skip           <= st_lt;
                px_ss_o.add_ln_skip_interval <= st_la;
                update_o <= 1'b1;
            end

            if (accept) begin
                x_cls     <= in_x_cls;
                y_cls     <= in_y_cls;
                y_src     <= src_res_y_i;
                err       <= in_x_cls.inv || in_y_cls.inv;
                cfg_err_o <= 1'b0;
                div_quo   <= {1'b0, src_res_x_i};
                div_dvs   <= in_x_cls.div1;
                div_rem   <= '0;
                div_cnt   <= '0;
            end else if (busy_o) begin
                div_rem <= rem_nx;
                div_quo <= quo_nx;
                div_cnt <= div_cnt + 1'b1;
                if (last) begin
                    div_cnt <= '0;
                    div_rem <= '0;
                    case (state)
                        CALC_X0: begin
                            st_pi   <= x_cls.eq ? '0 : quo_nx[W-1:0];
                            st_pt   <= x_cls.eq ? '0 : (x_cls.big ? W'(1) : quo_nx[W-1:0] - W'(1));
                            rz      <= (rem_nx == '0);
                            div_quo <= x_cls.div2;
                            div_dvs <= (rem_nx == '0) ? wide_t'(1) : rem_nx;
                        end
                        CALC_X1: begin
                            st_pa   <= (x_cls.eq || rz) ? '0 : quo_nx[W-1:0];
                            div_quo <= {1'b0, y_src};
                            div_dvs <= y_cls.div1;
                        end
                        CALC_Y0: begin
                            st_li   <= y_cls.eq ? '0 : quo_nx[W-1:0];
                            st_lt   <= y_cls.eq ? '0 : (y_cls.big ? W'(1) : quo_nx[W-1:0] - W'(1));
                            rz      <= (rem_nx == '0);
                            div_quo <= y_cls.div2;
                            div_dvs <= (rem_nx == '0) ? wide_t'(1) : rem_nx;
                        end
                        CALC_Y1: begin
                            st_la <= (y_cls.eq || rz) ? '0 : quo_nx[W-1:0];
                            if (err) cfg_err_o <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_px_ss_ctrl.sv
// tb_px_ss_ctrl: table-driven bench for px_ss_ctrl with a scoreboard of
// expected parameter sets popped on each update_o pulse. Works with or
// without PX_SS_CTRL_FRAME_SYNC_EN defined.
module tb_px_ss_ctrl;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] pi, pt, pa, li, lt, la;
    } ss_t;

    typedef struct {
        logic [W-1:0] sx, dx, sy, dy;
        bit           err;
        ss_t          f;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic [W-1:0] sx = '0, dx = '0, sy = '0, dy = '0;
    logic         ready, busy, pending, update, cfg_err;

    px_ss_if #(.RES_WIDTH(W)) ss();

    px_ss_ctrl #(.RES_WIDTH(W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (ready),
        .src_res_x_i   (sx),
        .dst_res_x_i   (dx),
        .src_res_y_i   (sy),
        .dst_res_y_i   (dy),
        .frame_start_i (frame_start),
        .px_ss_o       (ss),
        .busy_o        (busy),
        .pending_o     (pending),
        .update_o      (update),
        .cfg_err_o     (cfg_err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    ss_t  sb[$];
    ss_t  last_ss = '0;
    vec_t tbl[8];

`ifdef PX_SS_CTRL_FRAME_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic ss_t get_ss();
        return {ss.px_skip_interval, ss.px_to_skip, ss.add_px_skip_interval,
                ss.ln_skip_interval, ss.ln_to_skip, ss.add_ln_skip_interval};
    endfunction

    task automatic cmp_ss(input string tag, input ss_t exp);
        ss_t act;
        act = get_ss();
        check({tag, ".px_int"}, 32'(act.pi), 32'(exp.pi));
        check({tag, ".px_skip"}, 32'(act.pt), 32'(exp.pt));
        check({tag, ".px_add"}, 32'(act.pa), 32'(exp.pa));
        check({tag, ".ln_int"}, 32'(act.li), 32'(exp.li));
        check({tag, ".ln_skip"}, 32'(act.lt), 32'(exp.lt));
        check({tag, ".ln_add"}, 32'(act.la), 32'(exp.la));
    endtask

    // Drive a request in the current cycle (cycle 0); returns in cycle 1.
    task automatic accept(input vec_t v, input bit fs);
        check("ready_c0", 32'(ready), 32'd1);
        sx = v.sx; dx = v.dx; sy = v.sy; dy = v.dy;
        cfg_valid = 1'b1;
        frame_start = fs;
        if (!v.err) sb.push_back(v.f);
        tick();
        cfg_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    // Cycle 1 to cycle 69, with ignored requests and frame starts during calc.
    task automatic calc_phase();
        check("busy_c1", 32'(busy), 32'd1);
        check("ready_c1", 32'(ready), 32'd0);
        check("cfg_err_c1", 32'(cfg_err), 32'd0);
        repeat (67) begin
            cfg_valid = 1'b1;
            sx = W'($urandom); dx = W'($urandom);
            sy = W'($urandom); dy = W'($urandom);
            frame_start = 1'($urandom);
            tick();
        end
        cfg_valid = 1'b0;
        frame_start = 1'b0;
        check("busy_c68", 32'(busy), 32'd1);
        check("update_calc", 32'(update), 32'd0);
        tick();
        check("busy_c69", 32'(busy), 32'd0);
        check("ready_c69", 32'(ready), 32'd1);
    endtask

    // Pop scoreboard on update and compare.
    task automatic expect_update(input string tag);
        ss_t exp;
        check({tag, ".update"}, 32'(update), 32'd1);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s.scoreboard: got empty queue expected entry", tag);
        end else begin
            exp = sb.pop_front();
            cmp_ss(tag, exp);
            last_ss = exp;
        end
    endtask

    // From cycle 69 of a valid request: commit and verify.
    task automatic commit_exp(input string tag);
        check({tag, ".pending"}, 32'(pending), 32'(SYNC));
        check({tag, ".err"}, 32'(cfg_err), 32'd0);
        if (SYNC) begin
            cmp_ss({tag, ".hold"}, last_ss);
            frame_start = 1'b1;
        end
        tick();
        frame_start = 1'b0;
        expect_update(tag);
        tick();
        check({tag, ".update_end"}, 32'(update), 32'd0);
    endtask

    initial begin
        int n_upd;
        tbl[0] = '{16'd1920, 16'd1280, 16'd1080, 16'd720,  1'b0, '{16'd3, 16'd1, 16'd0, 16'd3, 16'd1, 16'd0}};
        tbl[1] = '{16'd1920, 16'd640,  16'd1080, 16'd1080, 1'b0, '{16'd3, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0}};
        tbl[2] = '{16'd1920, 16'd1366, 16'd1080, 16'd540,  1'b0, '{16'd3, 16'd1, 16'd2, 16'd2, 16'd1, 16'd0}};
        tbl[3] = '{16'd1920, 16'd2000, 16'd1080, 16'd720,  1'b1, '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
        tbl[4] = '{16'd1000, 16'd300,  16'd100,  16'd0,    1'b1, '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
        tbl[5] = '{16'd65535, 16'd1,   16'd65535, 16'd65534, 1'b0, '{16'd65535, 16'd65534, 16'd0, 16'd65535, 16'd1, 16'd0}};
        tbl[6] = '{16'd100,  16'd7,    16'd100,  16'd51,   1'b0, '{16'd14, 16'd13, 16'd3, 16'd2, 16'd1, 16'd24}};
        tbl[7] = '{16'd5,    16'd5,    16'd1,    16'd1,    1'b0, '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};

        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        check("rst.ready", 32'(ready), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.pending", 32'(pending), 32'd0);
        check("rst.update", 32'(update), 32'd0);
        check("rst.err", 32'(cfg_err), 32'd0);
        cmp_ss("rst", '0);
        rst = 1'b0;
        #1;
        check("rst.ready_release", 32'(ready), 32'd1);

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            accept(tbl[i], 1'b0);
            calc_phase();
            if (tbl[i].err) begin
                check({tag, ".cfg_err"}, 32'(cfg_err), 32'd1);
                check({tag, ".pending"}, 32'(pending), 32'd0);
                tick();
                check({tag, ".no_update"}, 32'(update), 32'd0);
                cmp_ss({tag, ".unchanged"}, last_ss);
                tick();
            end else begin
                commit_exp(tag);
            end
        end

        // New request at cycle 69 with coincident frame start: old set commits,
        // new one runs the full latency.
        accept(tbl[0], 1'b0);
        calc_phase();
        check("coinc.pending", 32'(pending), 32'(SYNC));
        accept(tbl[6], 1'b1);
        expect_update("coinc.old");
        calc_phase();
        commit_exp("coinc.new");

        // Reset at cycle 30 of a calculation aborts with no commit.
        accept(tbl[2], 1'b0);
        repeat (29) tick();
        rst = 1'b1;
        tick();
        check("abort.ready", 32'(ready), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.pending", 32'(pending), 32'd0);
        check("abort.err", 32'(cfg_err), 32'd0);
        tick();
        cmp_ss("abort", '0);
        rst = 1'b0;
        #1;
        check("abort.ready_release", 32'(ready), 32'd1);
        sb.delete();
        n_upd = 0;
        repeat (90) begin
            frame_start = 1'b1;
            tick();
            if (update === 1'b1) n_upd++;
        end
        frame_start = 1'b0;
        check("abort.no_update", 32'(n_upd), 32'd0);
        cmp_ss("abort.after", '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
